ita_hwpe_addrgen: RTL

ITA_HWPE_ADDRGEN -- requirements
Module: ita_hwpe_addrgen

---
 rtl/ita_hwpe_addrgen_pkg.sv | 32 +++
 rtl/ita_hwpe_addrgen_dim_cnt.sv | 38 +++
 rtl/ita_hwpe_addrgen.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ita_hwpe_addrgen_pkg.sv
// Shared types for the ITA HWPE address generator: FSM state encoding,
// the configuration snapshot taken on start, and default widths.
package ita_hwpe_package;

  localparam int unsigned ITA_ADDRGEN_ADDR_W  = 32;
  localparam int unsigned ITA_ADDRGEN_LEN_W   = 32;
  localparam int unsigned ITA_ADDRGEN_STALL_W = 32;

  typedef enum logic [1:0] {
    ADDRGEN_IDLE = 2'd0,
    ADDRGEN_RUN  = 2'd1,
    ADDRGEN_DONE = 2'd2
  } ita_addrgen_state_e;

  // Everything the generator needs for one sequence, frozen at start so the
  // controller may reprogram its inputs while a sequence is running.
  typedef struct packed {
    logic [ITA_ADDRGEN_ADDR_W-1:0] base_addr;
    logic [ITA_ADDRGEN_ADDR_W-1:0] d0_stride;
    logic [ITA_ADDRGEN_ADDR_W-1:0] d1_stride;
    logic [ITA_ADDRGEN_LEN_W-1:0]  tot_len;
    logic [ITA_ADDRGEN_LEN_W-1:0]  d0_len;
    logic [ITA_ADDRGEN_LEN_W-1:0]  d1_len;
    logic                          is_2d;
  } ita_addrgen_cfg_t;

  // Only 2'b00 selects 1D; every other code walks two dimensions.
  function automatic logic dim_is_2d(input logic [1:0] dim_enable_1h);
    return dim_enable_1h != 2'b00;
  endfunction

endpackage

// File: rtl/ita_hwpe_addrgen_dim_cnt.sv
// One dimension counter of the address generator: counts steps from 0 up to
// len-1 and then wraps to 0. A length of 0 behaves as a length of 1.
module ita_hwpe_addrgen_dim_cnt #(
  parameter int unsigned LEN_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             step_i,
  input  logic [LEN_W-1:0] len_i,
  output logic [LEN_W-1:0] cnt_o,
  output logic             wrap_o
);

  logic [LEN_W-1:0] last_idx;

  // Index of the final element of this dimension, with zero length folded to one.
  always_comb begin
    last_idx = '0;
    if (len_i != '0) begin
      last_idx = len_i - LEN_W'(1);
    end
  end

  assign wrap_o = (cnt_o == last_idx);

  // Step the count, returning to 0 after the last element; clear wins over step.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_o <= '0;
    end else if (clear_i) begin
      cnt_o <= '0;
    end else if (step_i) begin
      cnt_o <= wrap_o ? '0 : cnt_o + LEN_W'(1);
    end
  end

endmodule

// File: rtl/ita_hwpe_addrgen.sv
// ITA HWPE address generator: emits a 1D or 2D strided word-address stream
// over a valid/ready handshake, then pulses done_o.
// Optional feature macro ITA_ADDRGEN_STALL_CNT_EN enables the stall counter
// behind stall_cnt_o; without it the port reads constant 0.
module ita_hwpe_addrgen
  import ita_hwpe_package::*;
#(
  parameter int unsigned ADDR_W = ITA_ADDRGEN_ADDR_W,
  parameter int unsigned LEN_W  = ITA_ADDRGEN_LEN_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clear_i,
  input  logic              req_start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] d0_stride_i,
  input  logic [ADDR_W-1:0] d1_stride_i,
  input  logic [LEN_W-1:0]  tot_len_i,
  input  logic [LEN_W-1:0]  d0_len_i,
  input  logic [LEN_W-1:0]  d1_len_i,
  input  logic [1:0]        dim_enable_1h_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              addr_valid_o,
  input  logic              addr_ready_i,
  output logic              ready_start_o,
  output logic              done_o,
  output logic [31:0]       stall_cnt_o
);

  // The config snapshot struct is sized by the package widths.
  if (ADDR_W != ITA_ADDRGEN_ADDR_W || LEN_W != ITA_ADDRGEN_LEN_W) begin : g_width_check
    $error("ita_hwpe_addrgen: ADDR_W/LEN_W must match ita_hwpe_package widths");
  end

  ita_addrgen_state_e state_q;
  ita_addrgen_cfg_t   cfg_q;
  logic [LEN_W-1:0]   xfer_cnt_q;
  logic [ADDR_W-1:0]  outer_base_q;
  logic [ADDR_W-1:0]  next_outer;
  logic [ADDR_W-1:0]  next_addr;
  logic [LEN_W-1:0]   d0_cnt;
  logic [LEN_W-1:0]   d1_cnt;
  logic               d0_wrap;
  logic               d1_wrap;
  logic               xfer;
  logic               start_accept;
  logic               last_xfer;
  logic               dim_clear;
  logic               d0_step;
  logic               d1_step;
  logic               unused_signals;

  assign xfer         = (state_q == ADDRGEN_RUN) && addr_valid_o && addr_ready_i;
  assign start_accept = (state_q == ADDRGEN_IDLE) && req_start_i;
  assign last_xfer    = (xfer_cnt_q + LEN_W'(1)) == cfg_q.tot_len;
  assign dim_clear    = start_accept || clear_i;
  assign d0_step      = xfer && cfg_q.is_2d;
  assign d1_step      = d0_step && d0_wrap;

  assign unused_signals = ^{cfg_q.base_addr, d0_cnt, d1_cnt, d1_wrap};

  ita_hwpe_addrgen_dim_cnt #(.LEN_W(LEN_W)) i_dim0_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (dim_clear),
    .step_i  (d0_step),
    .len_i   (cfg_q.d0_len),
    .cnt_o   (d0_cnt),
    .wrap_o  (d0_wrap)
  );

  ita_hwpe_addrgen_dim_cnt #(.LEN_W(LEN_W)) i_dim1_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (dim_clear),
    .step_i  (d1_step),
    .len_i   (cfg_q.d1_len),
    .cnt_o   (d1_cnt),
    .wrap_o  (d1_wrap)
  );

  // Address after the current transfer: jump to the next outer row at the end
  // of an inner row in 2D, otherwise advance by the inner stride.
  always_comb begin
    next_outer = outer_base_q + cfg_q.d1_stride;
    next_addr  = addr_o + cfg_q.d0_stride;
    if (cfg_q.is_2d && d0_wrap) begin
      next_addr = next_outer;
    end
  end

  // Sequencing FSM with registered handshake outputs; clear aborts silently.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q       <= ADDRGEN_IDLE;
      cfg_q         <= '0;
      xfer_cnt_q    <= '0;
      outer_base_q  <= '0;
      addr_o        <= '0;
      addr_valid_o  <= 1'b0;
      ready_start_o <= 1'b1;
      done_o        <= 1'b0;
    end else if (clear_i) begin
      state_q       <= ADDRGEN_IDLE;
      addr_valid_o  <= 1'b0;
      ready_start_o <= 1'b1;
      done_o        <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state_q)
        ADDRGEN_IDLE: begin
          if (req_start_i) begin
            cfg_q.base_addr <= base_addr_i;
            cfg_q.d0_stride <= d0_stride_i;
            cfg_q.d1_stride <= d1_stride_i;
            cfg_q.tot_len   <= tot_len_i;
            cfg_q.d0_len    <= d0_len_i;
            cfg_q.d1_len    <= d1_len_i;
            cfg_q.is_2d     <= dim_is_2d(dim_enable_1h_i);
            xfer_cnt_q      <= '0;
            outer_base_q    <= base_addr_i;
            addr_o          <= base_addr_i;
            ready_start_o   <= 1'b0;
            if (tot_len_i == '0) begin
              state_q <= ADDRGEN_DONE;
              done_o  <= 1'b1;
            end else begin
              state_q      <= ADDRGEN_RUN;
              addr_valid_o <= 1'b1;
            end
          end
        end
        ADDRGEN_RUN: begin
          if (xfer) begin
            xfer_cnt_q <= xfer_cnt_q + LEN_W'(1);
            if (cfg_q.is_2d && d0_wrap) begin
              outer_base_q <= next_outer;
            end
            if (last_xfer) begin
              state_q      <= ADDRGEN_DONE;
              addr_valid_o <= 1'b0;
              done_o       <= 1'b1;
            end else begin
              addr_o <= next_addr;
            end
          end
        end
        ADDRGEN_DONE: begin
          state_q       <= ADDRGEN_IDLE;
          ready_start_o <= 1'b1;
        end
        default: begin
          state_q       <= ADDRGEN_IDLE;
          addr_valid_o  <= 1'b0;
          ready_start_o <= 1'b1;
        end
      endcase
    end
  end

`ifdef ITA_ADDRGEN_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Count backpressured Run cycles for this sequence, saturating at all-ones.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (start_accept) begin
      stall_cnt_q <= '0;
    end else if ((state_q == ADDRGEN_RUN) && addr_valid_o && !addr_ready_i &&
                 (stall_cnt_q != '1)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule
